alu_secuenciador: RTL and testbench
===================================

Name: alu_secuenciador

Overview:
Command sequencer and accumulator stage that sits directly upstream of the 8-bit ALU and also consumes what it produces. It accepts opcode/data commands over a valid/ready handshake and drives the ALU operand and select lines from registered state. It captures the ALU result and carry into an accumulator, and returns one result-plus-flags response per command. It also implements an 8-iteration shift-add multiply by reusing the ALU adder.

Parameters:
WIDTH, 8, data width; only 8 is supported because the ALU is fixed at 8 bits.
MUL_EN, 1, 1 enables the MUL opcode; 0 makes MUL behave as NOP.

Ports:
CLK  input  1  single clock; all state changes on the rising edge.
RST_N  input  1  asynchronous, active-low reset.
CMD_VALID  input  1  command present.
CMD_READY  output  1  block can accept a command.
CMD_OP  input  3  opcode: 000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 MUL, 110 CLR, 111 NOP.
CMD_DATA  input  8  command operand.
ALU_A  output  8  ALU input A.
ALU_B  output  8  ALU input B.
ALU_COND  output  2  ALU select: 00 add, 01 sub, 10 and, 11 or.
ALU_OUT  input  8  ALU result.
ALU_CARRY  input  1  ALU carry; always the carry of A+B, regardless of ALU_COND.
RES_VALID  output  1  response present.
RES_READY  input  1  consumer accepts the response.
RES_DATA  output  8  accumulator value after the command.
RES_C  output  1  carry/borrow/overflow flag.
RES_Z  output  1  1 when RES_DATA==0.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; ACC=0; operand register OPND=0; RES_VALID=0; RES_DATA=0; RES_C=0; RES_Z=0; ALU_A=0; ALU_B=0; ALU_COND=00; iteration counter=0.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - CMD_READY=1; it is 1 in IDLE only.
  - On CMD_VALID & CMD_READY at edge k: latch CMD_OP and CMD_DATA into OPND.
  - Go to MUL if op=MUL and MUL_EN=1; otherwise go to EXEC.
- EXEC (one cycle): ALU_A=ACC, ALU_B=OPND, ALU_COND selected by op. At edge k+1:
  - LOAD: ACC=OPND, C=0.
  - ADD: ACC=ALU_OUT, C=ALU_CARRY.
  - SUB: ACC=ALU_OUT, C=(ACC<OPND), a borrow computed locally; ALU_CARRY is ignored.
  - AND/OR: ACC=ALU_OUT, C=0.
  - CLR: ACC=0, C=0.
  - NOP, and MUL with MUL_EN=0: ACC unchanged, C=0.
  - Go to RESP. RES_VALID=1 after edge k+1, so single-cycle latency from acceptance is 1 edge.
- MUL (8 cycles, iteration i=0..7):
  - Product register P starts at 0; multiplicand M=ACC is captured on entry; multiplier is OPND.
  - Each cycle: ALU_A=P, ALU_B=(M<<i) truncated to 8 bits, ALU_COND=00.
  - If OPND[i]=1: P=ALU_OUT; sticky OV |= ALU_CARRY | (any bit of M lost by the shift).
  - If OPND[i]=0: P unchanged.
  - After the 8th iteration edge (k+8): ACC=P, C=OV, go to RESP, RES_VALID=1.
  - Required equivalence: C=1 exactly when ACC*OPND > 255; ACC = low 8 bits of the product.
- RESP:
  - RES_DATA=ACC, RES_C=C, RES_Z=(ACC==0). These hold stable while RES_VALID & !RES_READY.
  - On RES_READY, go to IDLE; RES_VALID=0 next cycle; CMD_READY=1 next cycle.
  - One command outstanding; maximum throughput is one command per 3 cycles (10 for MUL).
- ALU_A, ALU_B and ALU_COND are driven only from registers, with no combinational path from CMD_* to ALU_*. In IDLE and RESP they are held at the last-driven values.
- CMD_VALID while not in IDLE is ignored; the command is not consumed.
- Reset asserted mid-EXEC or mid-MUL aborts the operation: no response is produced and all state returns to reset values.
- ACC persists across commands; wrap-around is modulo 256.

Test Plan:
- Reset, then LOAD 0x80 and ADD 0x90 -> RES_DATA=0x10, RES_C=1, RES_Z=0; RES_VALID rises 1 edge after the ADD handshake.
- From ACC=0x10, SUB 0x20 -> 0xF0, C=1. Then SUB 0xF0 -> 0x00, C=0, Z=1.
- LOAD 0x5A, AND 0x0F -> 0x0A, C=0. Then OR 0xA0 -> 0xAA, C=0.
- LOAD 0x0F, MUL 0x11 -> 0xFF, C=0, RES_VALID 8 edges after the handshake. Then MUL 0x02 -> 0xFE, C=1.
- Hold RES_READY=0 for 5 cycles after ADD -> RES_DATA/RES_C/RES_Z stable and CMD_READY=0 throughout; CMD_VALID pulses during RESP are not consumed.
- Drop RST_N during MUL iteration 4 (ACC=0x0F, MUL 0x11) -> ACC=0, RES_VALID stays 0, CMD_READY=1 after release; CMD_OP=111 then returns ACC unchanged with C=0.

Source files
------------

// File: rtl/alu_secuenciador.sv
// alu_secuenciador
// Command sequencer and accumulator that drives an external 8-bit ALU and
// consumes its result. Each accepted command produces one response carrying
// the accumulator value and flags. MUL is an 8-step shift-add multiply that
// reuses the ALU adder.
//
// Ports:
//   CLK, RST_N                  clock; asynchronous active-low reset
//   CMD_VALID/CMD_READY         command handshake (ready only in IDLE)
//   CMD_OP[2:0], CMD_DATA[7:0]  opcode and operand
//   ALU_A, ALU_B, ALU_COND      registered ALU operand/select lines
//   ALU_OUT, ALU_CARRY          ALU result; carry is always that of A+B
//   RES_VALID/RES_READY         response handshake
//   RES_DATA, RES_C, RES_Z      accumulator after command, carry flag, zero flag
module alu_secuenciador #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_OP,
    input  logic [WIDTH-1:0] CMD_DATA,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [1:0]       ALU_COND,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             ALU_CARRY,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_DATA,
    output logic             RES_C,
    output logic             RES_Z
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW:0]   WIDTH_L   = (CW + 1)'(WIDTH);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             ov_q, ov_d;
    logic [CW-1:0]    iter_q, iter_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_cond_q, alu_cond_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_c_q, res_c_d;
    logic             res_z_q, res_z_d;

    logic [WIDTH-1:0] p_next;
    logic             c_next;
    logic             lost_bits;

    // Bits of M pushed past the top by the current shift (none for i=0).
    assign lost_bits = |(m_q >> (WIDTH_L - {1'b0, iter_q}));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        op_d        = op_q;
        p_d         = p_q;
        m_d         = m_q;
        ov_d        = ov_q;
        iter_d      = iter_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cond_d  = alu_cond_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_c_d     = res_c_q;
        res_z_d     = res_z_q;
        p_next      = p_q;
        c_next      = 1'b0;

        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    op_d   = CMD_OP;
                    opnd_d = CMD_DATA;
                    if (CMD_OP == OP_MUL && MUL_EN) begin
                        // First iteration adds M<<0 onto a zero product.
                        state_d    = MUL;
                        p_d        = '0;
                        m_d        = acc_q;
                        ov_d       = 1'b0;
                        iter_d     = '0;
                        alu_a_d    = '0;
                        alu_b_d    = acc_q;
                        alu_cond_d = 2'b00;
                    end else begin
                        state_d = EXEC;
                        alu_a_d = acc_q;
                        alu_b_d = CMD_DATA;
                        case (CMD_OP)
                            OP_SUB:  alu_cond_d = 2'b01;
                            OP_AND:  alu_cond_d = 2'b10;
                            OP_OR:   alu_cond_d = 2'b11;
                            default: alu_cond_d = 2'b00;
                        endcase
                    end
                end
            end
            EXEC: begin
                case (op_q)
                    OP_LOAD: acc_d = opnd_q;
                    OP_ADD: begin
                        acc_d  = ALU_OUT;
                        c_next = ALU_CARRY;
                    end
                    OP_SUB: begin
                        // ALU carry is that of A+B, so the borrow is formed here.
                        acc_d  = ALU_OUT;
                        c_next = (acc_q < opnd_q);
                    end
                    OP_AND, OP_OR: acc_d = ALU_OUT;
                    OP_CLR:  acc_d = '0;
                    default: acc_d = acc_q;
                endcase
                state_d     = RESP;
                res_valid_d = 1'b1;
                res_data_d  = acc_d;
                res_c_d     = c_next;
                res_z_d     = (acc_d == '0);
            end
            MUL: begin
                if (opnd_q[iter_q]) begin
                    p_next = ALU_OUT;
                    ov_d   = ov_q | ALU_CARRY | lost_bits;
                end
                p_d = p_next;
                if (iter_q == LAST_ITER) begin
                    acc_d       = p_next;
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_data_d  = p_next;
                    res_c_d     = ov_d;
                    res_z_d     = (p_next == '0);
                end else begin
                    iter_d  = iter_q + 1'b1;
                    alu_a_d = p_next;
                    alu_b_d = m_q << (iter_q + 1'b1);
                end
            end
            RESP: begin
                if (RES_READY) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            opnd_q      <= '0;
            op_q        <= 3'b111;
            p_q         <= '0;
            m_q         <= '0;
            ov_q        <= 1'b0;
            iter_q      <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cond_q  <= 2'b00;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_c_q     <= 1'b0;
            res_z_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            op_q        <= op_d;
            p_q         <= p_d;
            m_q         <= m_d;
            ov_q        <= ov_d;
            iter_q      <= iter_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cond_q  <= alu_cond_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_c_q     <= res_c_d;
            res_z_q     <= res_z_d;
        end
    end

    assign CMD_READY = (state_q == IDLE);
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_COND  = alu_cond_q;
    assign RES_VALID = res_valid_q;
    assign RES_DATA  = res_data_q;
    assign RES_C     = res_c_q;
    assign RES_Z     = res_z_q;

endmodule

// File: tb/tb_alu_secuenciador.sv
// Directed bench for alu_secuenciador with a behavioural 8-bit ALU attached.
module tb_alu_secuenciador;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [2:0] CMD_OP = 3'b111;
    logic [7:0] CMD_DATA = 8'h00;
    logic [7:0] ALU_A, ALU_B, ALU_OUT;
    logic [1:0] ALU_COND;
    logic       ALU_CARRY;
    logic       RES_VALID;
    logic       RES_READY = 1'b0;
    logic [7:0] RES_DATA;
    logic       RES_C, RES_Z;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    alu_secuenciador #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_COND(ALU_COND),
        .ALU_OUT(ALU_OUT), .ALU_CARRY(ALU_CARRY),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_C(RES_C), .RES_Z(RES_Z)
    );

    // Reference ALU: carry is always that of A+B.
    logic [8:0] alu_sum;
    assign alu_sum   = {1'b0, ALU_A} + {1'b0, ALU_B};
    assign ALU_CARRY = alu_sum[8];
    always_comb begin
        case (ALU_COND)
            2'b00:   ALU_OUT = alu_sum[7:0];
            2'b01:   ALU_OUT = ALU_A - ALU_B;
            2'b10:   ALU_OUT = ALU_A & ALU_B;
            default: ALU_OUT = ALU_A | ALU_B;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, measure edges to RES_VALID, check the response,
    // optionally stall the consumer for 'hold' cycles, then accept it.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [7:0] data,
                          input logic [1:0] e_cond, input logic [7:0] e_data,
                          input logic e_c, input int e_lat, input int hold);
        int n;
        int w;
        logic e_z;
        e_z = (e_data == 8'h00);
        w = 0;
        @(negedge CLK);
        while (!CMD_READY && w < 50) begin
            @(negedge CLK);
            w++;
        end
        chk({tag, "_ready"}, {7'd0, CMD_READY}, 8'd1);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_DATA  = data;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        CMD_OP    = 3'b111;
        CMD_DATA  = 8'h00;
        chk({tag, "_busy"}, {7'd0, CMD_READY}, 8'd0);
        chk({tag, "_cond"}, {6'd0, ALU_COND}, {6'd0, e_cond});
        n = 0;
        while (!RES_VALID && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n[7:0], e_lat[7:0]);
        chk({tag, "_data"}, RES_DATA, e_data);
        chk({tag, "_c"}, {7'd0, RES_C}, {7'd0, e_c});
        chk({tag, "_z"}, {7'd0, RES_Z}, {7'd0, e_z});
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            CMD_VALID = (i % 2 == 0);
            CMD_OP    = 3'b110;
            chk({tag, "_hold_v"}, {7'd0, RES_VALID}, 8'd1);
            chk({tag, "_hold_d"}, RES_DATA, e_data);
            chk({tag, "_hold_c"}, {7'd0, RES_C}, {7'd0, e_c});
            chk({tag, "_hold_z"}, {7'd0, RES_Z}, {7'd0, e_z});
            chk({tag, "_hold_rdy"}, {7'd0, CMD_READY}, 8'd0);
        end
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_OP    = 3'b111;
        RES_READY = 1'b1;
        @(posedge CLK);
        #1;
        RES_READY = 1'b0;
        chk({tag, "_done_v"}, {7'd0, RES_VALID}, 8'd0);
        chk({tag, "_done_rdy"}, {7'd0, CMD_READY}, 8'd1);
        $display("cmd %s op=%0d data=%02h -> res=%02h c=%0b z=%0b lat=%0d",
                 tag, op, data, RES_DATA, RES_C, RES_Z, n);
    endtask

    initial begin
        int seen_valid;
        // Reset state
        #12;
        chk("rst_valid", {7'd0, RES_VALID}, 8'd0);
        chk("rst_data", RES_DATA, 8'h00);
        chk("rst_c", {7'd0, RES_C}, 8'd0);
        chk("rst_z", {7'd0, RES_Z}, 8'd0);
        chk("rst_a", ALU_A, 8'h00);
        chk("rst_b", ALU_B, 8'h00);
        chk("rst_cond", {6'd0, ALU_COND}, 8'd0);
        chk("rst_ready", {7'd0, CMD_READY}, 8'd1);
        @(negedge CLK);
        RST_N = 1'b1;

        // LOAD then ADD with overflow; consumer stalls 5 cycles, CLR pulses ignored
        do_cmd("load80", 3'b000, 8'h80, 2'b00, 8'h80, 1'b0, 1, 0);
        do_cmd("add90", 3'b001, 8'h90, 2'b00, 8'h10, 1'b1, 1, 5);
        // SUB with borrow, then SUB to zero
        do_cmd("sub20", 3'b010, 8'h20, 2'b01, 8'hF0, 1'b1, 1, 0);
        do_cmd("subF0", 3'b010, 8'hF0, 2'b01, 8'h00, 1'b0, 1, 0);
        // Logic ops
        do_cmd("load5A", 3'b000, 8'h5A, 2'b00, 8'h5A, 1'b0, 1, 0);
        do_cmd("and0F", 3'b011, 8'h0F, 2'b10, 8'h0A, 1'b0, 1, 0);
        do_cmd("orA0", 3'b100, 8'hA0, 2'b11, 8'hAA, 1'b0, 1, 0);
        // Multiply: 0x0F*0x11=0xFF, then 0xFF*2=0x1FE (overflow via shift)
        do_cmd("load0F", 3'b000, 8'h0F, 2'b00, 8'h0F, 1'b0, 1, 0);
        do_cmd("mul11", 3'b101, 8'h11, 2'b00, 8'hFF, 1'b0, 8, 0);
        do_cmd("mul02", 3'b101, 8'h02, 2'b00, 8'hFE, 1'b1, 8, 0);
        // 0x60*3=0x120: overflow only through the adder carry
        do_cmd("load60", 3'b000, 8'h60, 2'b00, 8'h60, 1'b0, 1, 0);
        do_cmd("mul03", 3'b101, 8'h03, 2'b00, 8'h20, 1'b1, 8, 0);
        // CLR and NOP
        do_cmd("clr", 3'b110, 8'h33, 2'b00, 8'h00, 1'b0, 1, 0);
        do_cmd("load77", 3'b000, 8'h77, 2'b00, 8'h77, 1'b0, 1, 0);
        do_cmd("nop", 3'b111, 8'h12, 2'b00, 8'h77, 1'b0, 1, 0);

        // Reset during MUL iteration 4 aborts it
        do_cmd("load0F_b", 3'b000, 8'h0F, 2'b00, 8'h0F, 1'b0, 1, 0);
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_OP    = 3'b101;
        CMD_DATA  = 8'h11;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        CMD_OP    = 3'b111;
        repeat (4) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("abort_valid", {7'd0, RES_VALID}, 8'd0);
        chk("abort_ready", {7'd0, CMD_READY}, 8'd1);
        chk("abort_data", RES_DATA, 8'h00);
        chk("abort_a", ALU_A, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        seen_valid = 0;
        repeat (10) begin
            @(negedge CLK);
            if (RES_VALID) seen_valid++;
        end
        chk("abort_noresp", seen_valid[7:0], 8'd0);
        chk("abort_ready2", {7'd0, CMD_READY}, 8'd1);
        $display("abort mul during iteration 4 -> res_valid=%0b ready=%0b", RES_VALID, CMD_READY);
        do_cmd("nop_after", 3'b111, 8'h55, 2'b00, 8'h00, 1'b0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
